// File: rtl/gio_arbiter_if.sv
// Bundle of both requester handshakes and the shared GPIO output bus.
// The arbiter uses the slave modport; requesters and bus consumers use master.
interface gio_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             m0_valid;
   logic [31:0]      m0_addr;
   logic [31:0]      m0_wdata;
   logic [3:0]       m0_wstrb;
   logic             m0_ready;
   logic [31:0]      m0_rdata;

   logic             m1_valid;
   logic [31:0]      m1_addr;
   logic [31:0]      m1_wdata;
   logic [3:0]       m1_wstrb;
   logic             m1_ready;
   logic [31:0]      m1_rdata;

   logic [31:0]      io_addr;
   logic [WIDTH-1:0] io_wdata;
   logic             io_wen;

   modport master (
      output m0_valid, m0_addr, m0_wdata, m0_wstrb,
      input  m0_ready, m0_rdata,
      output m1_valid, m1_addr, m1_wdata, m1_wstrb,
      input  m1_ready, m1_rdata,
      input  io_addr, io_wdata, io_wen
   );

   modport slave (
      input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
      output m0_ready, m0_rdata,
      input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
      output m1_ready, m1_rdata,
      output io_addr, io_wdata, io_wen
   );
endinterface

// File: rtl/gio_arbiter.sv
// Round-robin two-requester sequencer for the GPIO output bus (IDLE -> ACCESS -> ACK).
// Define GIO_ARB_READBACK_EN to build the shadow register returned on window reads.
module gio_arbiter #(
   parameter int          WIDTH     = 8,
   parameter logic [31:0] BASE_ADDR = 32'h01000000,
   parameter logic [31:0] ADDR_MASK = 32'hFF000000
) (
   input  logic          clk,
   input  logic          resetn,
   gio_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   function automatic logic f_win_hit(input logic [31:0] addr);
      return (addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
   endfunction

   state_t            r_state;
   logic              r_last_grant;
   logic              r_grant;
   logic [31:0]       r_io_addr;
   logic [WIDTH-1:0]  r_io_wdata;
   logic              r_io_wen;
   logic              r_m0_ready;
   logic              r_m1_ready;
   logic [31:0]       r_m0_rdata;
   logic [31:0]       r_m1_rdata;

   state_t            w_state_nxt;
   logic              w_last_nxt;
   logic              w_grant_nxt;
   logic [31:0]       w_io_addr_nxt;
   logic [WIDTH-1:0]  w_io_wdata_nxt;
   logic              w_io_wen_nxt;
   logic              w_m0_ready_nxt;
   logic              w_m1_ready_nxt;
   logic [31:0]       w_m0_rdata_nxt;
   logic [31:0]       w_m1_rdata_nxt;

   logic              w_grant_en;
   logic              w_grant_sel;
   logic [31:0]       w_sel_addr;
   logic [31:0]       w_sel_wdata;
   logic [3:0]        w_sel_wstrb;
   logic [WIDTH-1:0]  w_rd_val;
   logic [31:0]       w_rdata_word;
   logic              w_unused;

   // On a tie the requester that did not win last time is picked.
   assign w_grant_en   = bus.m0_valid | bus.m1_valid;
   assign w_grant_sel  = bus.m1_valid & (~bus.m0_valid | ~r_last_grant);
   assign w_sel_addr   = w_grant_sel ? bus.m1_addr  : bus.m0_addr;
   assign w_sel_wdata  = w_grant_sel ? bus.m1_wdata : bus.m0_wdata;
   assign w_sel_wstrb  = w_grant_sel ? bus.m1_wstrb : bus.m0_wstrb;
   assign w_rdata_word = {{(32-WIDTH){1'b0}}, w_rd_val};

`ifdef GIO_ARB_READBACK_EN
   logic [WIDTH-1:0]  r_shadow;
   logic              r_rd_hit;

   // Shadow of the last bus write plus a flag marking the granted access as a window read.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_shadow <= {WIDTH{1'b0}};
         r_rd_hit <= 1'b0;
      end else begin
         if (r_io_wen) begin
            r_shadow <= r_io_wdata;
         end
         if ((r_state == ST_IDLE) && w_grant_en) begin
            r_rd_hit <= (w_sel_wstrb == 4'h0) && f_win_hit(w_sel_addr);
         end
      end
   end

   assign w_rd_val = r_rd_hit ? r_shadow : {WIDTH{1'b0}};
   assign w_unused = ^{w_sel_wdata[31:WIDTH]};
`else
   assign w_rd_val = {WIDTH{1'b0}};
   assign w_unused = ^{w_sel_wdata[31:WIDTH], w_sel_wstrb[3:1]};
`endif

   // Next state plus next value of every registered output; outputs idle at 0 by default.
   always_comb begin
      w_state_nxt    = r_state;
      w_last_nxt     = r_last_grant;
      w_grant_nxt    = r_grant;
      w_io_addr_nxt  = 32'h0;
      w_io_wdata_nxt = {WIDTH{1'b0}};
      w_io_wen_nxt   = 1'b0;
      w_m0_ready_nxt = 1'b0;
      w_m1_ready_nxt = 1'b0;
      w_m0_rdata_nxt = 32'h0;
      w_m1_rdata_nxt = 32'h0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_en) begin
               w_state_nxt    = ST_ACCESS;
               w_last_nxt     = w_grant_sel;
               w_grant_nxt    = w_grant_sel;
               w_io_addr_nxt  = w_sel_addr;
               w_io_wdata_nxt = w_sel_wdata[WIDTH-1:0];
               w_io_wen_nxt   = w_sel_wstrb[0] & f_win_hit(w_sel_addr);
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            w_state_nxt = ST_ACK;
            if (r_grant) begin
               w_m1_ready_nxt = 1'b1;
               w_m1_rdata_nxt = w_rdata_word;
            end else begin
               w_m0_ready_nxt = 1'b1;
               w_m0_rdata_nxt = w_rdata_word;
            end
         end
         ST_ACK: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_io_addr    <= 32'h0;
         r_io_wdata   <= {WIDTH{1'b0}};
         r_io_wen     <= 1'b0;
         r_m0_ready   <= 1'b0;
         r_m1_ready   <= 1'b0;
         r_m0_rdata   <= 32'h0;
         r_m1_rdata   <= 32'h0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_nxt;
         r_grant      <= w_grant_nxt;
         r_io_addr    <= w_io_addr_nxt;
         r_io_wdata   <= w_io_wdata_nxt;
         r_io_wen     <= w_io_wen_nxt;
         r_m0_ready   <= w_m0_ready_nxt;
         r_m1_ready   <= w_m1_ready_nxt;
         r_m0_rdata   <= w_m0_rdata_nxt;
         r_m1_rdata   <= w_m1_rdata_nxt;
      end
   end

   assign bus.io_addr  = r_io_addr;
   assign bus.io_wdata = r_io_wdata;
   assign bus.io_wen   = r_io_wen;
   assign bus.m0_ready = r_m0_ready;
   assign bus.m1_ready = r_m1_ready;
   assign bus.m0_rdata = r_m0_rdata;
   assign bus.m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_gio_arbiter.sv
// Directed, table-driven bench for gio_arbiter: one row per clock, plus a mid-access reset sequence.
// Readback expectations follow GIO_ARB_READBACK_EN.
module tb_gio_arbiter;

   typedef struct {
      logic        v;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } req_t;

   typedef struct {
      req_t        q0;
      req_t        q1;
      logic        wen;
      logic [31:0] ioa;
      logic [7:0]  iod;
      logic        r0;
      logic        r1;
      logic [31:0] rd0;
      logic [31:0] rd1;
   } vec_t;

   localparam logic [31:0] A_HIT  = 32'h01000000;
   localparam logic [31:0] A_HIT8 = 32'h01000008;
   localparam logic [31:0] A_MISS = 32'h02000000;
`ifdef GIO_ARB_READBACK_EN
   localparam logic [31:0] RB = 32'h000000ac;
`else
   localparam logic [31:0] RB = 32'h00000000;
`endif

   logic clk;
   logic resetn;
   int   n_pass;
   int   n_total;
   vec_t vecs[$];

   gio_arbiter_if #(.WIDTH(8)) bus ();

   gio_arbiter #(
      .WIDTH(8),
      .BASE_ADDR(32'h01000000),
      .ADDR_MASK(32'hFF000000)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic req_t rq(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      req_t r;
      r.v = v; r.a = a; r.d = d; r.s = s;
      return r;
   endfunction

   function automatic vec_t mk(input req_t q0, input req_t q1, input logic wen, input logic [31:0] ioa,
                               input logic [7:0] iod, input logic r0, input logic r1,
                               input logic [31:0] rd0, input logic [31:0] rd1);
      vec_t v;
      v.q0 = q0; v.q1 = q1; v.wen = wen; v.ioa = ioa; v.iod = iod;
      v.r0 = r0; v.r1 = r1; v.rd0 = rd0; v.rd1 = rd1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input req_t q0, input req_t q1);
      bus.m0_valid = q0.v; bus.m0_addr = q0.a; bus.m0_wdata = q0.d; bus.m0_wstrb = q0.s;
      bus.m1_valid = q1.v; bus.m1_addr = q1.a; bus.m1_wdata = q1.d; bus.m1_wstrb = q1.s;
   endtask

   task automatic chk_all(input string tag, input logic wen, input logic [31:0] ioa, input logic [7:0] iod,
                          input logic r0, input logic r1, input logic [31:0] rd0, input logic [31:0] rd1);
      chk({tag, " io_wen"},   {31'h0, bus.io_wen},   {31'h0, wen});
      chk({tag, " io_addr"},  bus.io_addr,           ioa);
      chk({tag, " io_wdata"}, {24'h0, bus.io_wdata}, {24'h0, iod});
      chk({tag, " m0_ready"}, {31'h0, bus.m0_ready}, {31'h0, r0});
      chk({tag, " m1_ready"}, {31'h0, bus.m1_ready}, {31'h0, r1});
      chk({tag, " m0_rdata"}, bus.m0_rdata,          rd0);
      chk({tag, " m1_rdata"}, bus.m1_rdata,          rd1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      req_t idle;
      req_t p0;
      req_t p1;
      n_pass  = 0;
      n_total = 0;
      idle = rq(1'b0, 32'h0, 32'h0, 4'h0);

      // Both requesters hold valid continuously: grants alternate m0, m1, m0, m1.
      p0 = rq(1'b1, A_HIT, 32'h11, 4'hf);
      p1 = rq(1'b1, A_HIT, 32'h22, 4'hf);
      for (int k = 0; k < 2; k++) begin
         vecs.push_back(mk(p0, p1, 1'b1, A_HIT, 8'h11, 1'b0, 1'b0, 32'h0, 32'h0));
         vecs.push_back(mk(p0, p1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0));
         vecs.push_back(mk(p0, p1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
         vecs.push_back(mk(p0, p1, 1'b1, A_HIT, 8'h22, 1'b0, 1'b0, 32'h0, 32'h0));
         vecs.push_back(mk(p0, p1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0, 32'h0));
         vecs.push_back(mk(p0, p1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      end
      // Single m0 write: one strobe, ready one cycle later, no re-grant after ACK.
      p0 = rq(1'b1, A_HIT, 32'hab, 4'hf);
      vecs.push_back(mk(p0, idle, 1'b1, A_HIT, 8'hab, 1'b0, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(p0, idle, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(p0, idle, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(idle, idle, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      // m1 write outside the window: address/data shown, no strobe, still completes.
      p1 = rq(1'b1, A_MISS, 32'h55, 4'hf);
      vecs.push_back(mk(idle, p1, 1'b0, A_MISS, 8'h55, 1'b0, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(idle, p1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0, 32'h0));
      vecs.push_back(mk(idle, p1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      // m0 write with wstrb=2 in the window: no strobe, still completes.
      p0 = rq(1'b1, A_HIT8, 32'h77, 4'h2);
      vecs.push_back(mk(p0, idle, 1'b0, A_HIT8, 8'h77, 1'b0, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(p0, idle, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(p0, idle, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      // Write 0xac, then reads: m0 hit, m1 miss, m1 hit.
      p0 = rq(1'b1, A_HIT, 32'hac, 4'hf);
      vecs.push_back(mk(p0, idle, 1'b1, A_HIT, 8'hac, 1'b0, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(p0, idle, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(p0, idle, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      p0 = rq(1'b1, A_HIT, 32'h0, 4'h0);
      vecs.push_back(mk(p0, idle, 1'b0, A_HIT, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(p0, idle, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, RB, 32'h0));
      vecs.push_back(mk(p0, idle, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      p1 = rq(1'b1, A_MISS, 32'h0, 4'h0);
      vecs.push_back(mk(idle, p1, 1'b0, A_MISS, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(idle, p1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0, 32'h0));
      vecs.push_back(mk(idle, p1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      p1 = rq(1'b1, A_HIT8, 32'h0, 4'h0);
      vecs.push_back(mk(idle, p1, 1'b0, A_HIT8, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));
      vecs.push_back(mk(idle, p1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0, RB));
      vecs.push_back(mk(idle, p1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0));

      resetn = 1'b0;
      drive(idle, idle);
      #12;
      chk_all("reset", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
      #10;
      resetn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].q0, vecs[i].q1);
         step();
         chk_all($sformatf("row%0d", i), vecs[i].wen, vecs[i].ioa, vecs[i].iod,
                 vecs[i].r0, vecs[i].r1, vecs[i].rd0, vecs[i].rd1);
      end

      // Reset during ACCESS: strobe falls at once, no ready ever follows.
      drive(rq(1'b1, A_HIT, 32'h5a, 4'hf), idle);
      step();
      chk_all("pre_abort", 1'b1, A_HIT, 8'h5a, 1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      resetn = 1'b0;
      #1;
      chk_all("abort_async", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(idle, idle);
      step();
      chk_all("abort_held", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
      resetn = 1'b1;
      for (int j = 0; j < 3; j++) begin
         step();
         chk_all($sformatf("post_abort%0d", j), 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
      end

      // After reset m0 must win a tie again.
      drive(rq(1'b1, A_HIT, 32'h33, 4'hf), rq(1'b1, A_HIT, 32'h44, 4'hf));
      step();
      chk_all("tie0_access", 1'b1, A_HIT, 8'h33, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      chk_all("tie0_ack", 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);
      step();
      drive(idle, rq(1'b1, A_HIT, 32'h44, 4'hf));
      step();
      chk_all("tie1_access", 1'b1, A_HIT, 8'h44, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      chk_all("tie1_ack", 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0, 32'h0);
      drive(idle, idle);
      step();
      step();
      chk_all("final_idle", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gio_arbiter.md
Name: gio_arbiter

Overview:
- Two-requester write arbiter and sequencer for the shared memory-mapped GPIO output bus (io_addr/io_wdata/io_wen) that feeds the outport instances.
- Requester 0 is the picoRV32 native memory port; requester 1 is a secondary master (DMA/pattern engine). Both use the picoRV32 valid/ready handshake.
- Serialises accesses round-robin and generates a single-cycle write strobe per granted write.
- Completes each access with a one-cycle ready.

Parameters:
- WIDTH, 8, width of io_wdata and of the readback shadow register.
- BASE_ADDR, 32'h01000000, base of the GPIO address window.
- ADDR_MASK, 32'hFF000000, bits compared for a window hit.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- m0_valid  input  1  requester 0 request; held until m0_ready.
- m0_addr  input  32  requester 0 byte address.
- m0_wdata  input  32  requester 0 write data.
- m0_wstrb  input  4  requester 0 byte strobes; 0 means read.
- m0_ready  output  1  requester 0 completion pulse.
- m0_rdata  output  32  requester 0 read data, valid with m0_ready.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0_*, for requester 1.
- io_addr  output  32  shared GPIO bus address.
- io_wdata  output  WIDTH  shared GPIO bus data.
- io_wen  output  1  shared GPIO bus write strobe.

Behaviour:
- Reset, asserted asynchronously:
  - state = IDLE, last_grant = 1 (so m0 wins the first tie), shadow = 0.
  - io_addr = 0, io_wdata = 0, io_wen = 0.
  - m0_ready = m1_ready = 0, m0_rdata = m1_rdata = 0.
- Reset mid-operation aborts immediately: io_wen and any ready fall asynchronously; no pending write is ever issued after resetn rises.
- Window hit: (addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK).
- FSM states: IDLE, ACCESS, ACK.
  - IDLE:
    - Only one valid: grant it.
    - Both valid: grant the requester that is not last_grant.
    - On grant: latch the granted addr/wdata/wstrb and the grant index, update last_grant, go to ACCESS.
    - No valid: stay in IDLE.
  - ACCESS (exactly 1 cycle):
    - io_addr = latched addr, io_wdata = latched wdata[WIDTH-1:0].
    - io_wen = 1 only if wstrb[0] = 1 and the window hits.
    - On that write, shadow <= wdata[WIDTH-1:0].
    - Next state: ACK.
  - ACK (exactly 1 cycle):
    - Granted mX_ready = 1 and mX_rdata driven (see Optional Feature); the other requester's ready stays 0.
    - io_wen = 0, io_addr = 0, io_wdata = 0.
    - Next state: IDLE.
- Outside ACCESS, io_addr, io_wdata and io_wen are all 0. All outputs are registered.
- Latency: valid sampled in IDLE at edge N; io_wen high in cycle N+1; ready high in cycle N+2. Back-to-back throughput is one access per 3 cycles.
- Requester behaviour: drops valid on the edge where it samples ready high (picoRV32 behaviour). The arbiter never re-grants a request on the ACK→IDLE edge.
- Window miss or wstrb[0] = 0 with a nonzero wstrb: no io_wen, but the access still completes with ready (no bus hang).
- Read (wstrb = 0): no io_wen; completes with ready.
- The latched request is immune to input changes after the grant. A requester dropping valid early is a protocol violation; the access completes regardless.
- Fairness under continuous requests from both sides: grants strictly alternate.

Optional Feature:
- Macro: GIO_ARB_READBACK_EN.
- Defined: on ACK of a read to a window hit, mX_rdata = {zeros, shadow}, i.e. the last value written through the bus. Writes and misses return 0.
- Undefined: the shadow register is not built and mX_rdata is always 0. Timing and handshake are unchanged.

Test Plan:
- Reset then m0 write addr=32'h01000000, wdata=32'hab, wstrb=4'hf → io_wen=1 for exactly 1 cycle with io_addr=32'h01000000, io_wdata=8'hab; m0_ready 1 cycle later; m1_ready stays 0.
- m0 and m1 valid on the same edge after reset (m0 wdata=8'h11, m1 wdata=8'h22) → io_wdata 8'h11 first, then 8'h22; held continuously → grants alternate m0, m1, m0, m1.
- m1 write addr=32'h02000000 → no io_wen; m1_ready pulses 2 cycles after sampling.
- With GIO_ARB_READBACK_EN: write 8'hac, then m0 read of 32'h01000000 → m0_rdata=32'h000000ac with m0_ready. Without the macro → m0_rdata=0.
- resetn pulled low during ACCESS → io_wen drops immediately; no ready issued; after release, idle bus with all outputs 0.
- m0 write with wstrb=4'h2 inside the window → no io_wen; m0_ready still asserted 2 cycles after sampling.
